// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types and constants for the L1 main-memory arbiter: FSM state
// encoding, block geometry, the latched request record and a beat extractor.
package mem_arb_pkg;

    localparam int WORD_W     = 16;
    localparam int BEATS      = 8;
    localparam int BLK_W      = 128;
    localparam int BLK_ADDR_W = 12;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                  wb;
        logic [BLK_ADDR_W-1:0] waddr;
        logic [BLK_ADDR_W-1:0] raddr;
        logic [BLK_W-1:0]      wblock;
    } arb_req_t;

    // Word 'idx' of a block; word 0 sits in the least significant bits.
    function automatic logic [WORD_W-1:0] beat_word(input logic [BLK_W-1:0] blk,
                                                    input logic [CNT_W-1:0] idx);
        return blk[int'(idx)*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/l1_mem_arbiter_if.sv
// Word-wide main-memory beat port. master = arbiter side, slave = memory side.
interface l1_mem_arbiter_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 15
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/l1_mem_arbiter_pick.sv
// Winner select between the I and D miss engines. With ROUND_ROBIN_EN the
// last winner is remembered and loses the next tie; otherwise D always wins.
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic win_d,
    output logic any_req
);

    assign any_req = i_req | d_req;

`ifdef ROUND_ROBIN_EN
    logic last_d_q;
    logic last_d_d;

    // Pick D unless I is also asking and D won the previous grant.
    always_comb begin
        win_d = d_req & (~i_req | ~last_d_q);
        if (grant_en) begin
            last_d_d = win_d;
        end else begin
            last_d_d = last_d_q;
        end
    end

    // Last-winner pointer; reset value lets D take the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign win_d = d_req;
`endif

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one word-wide memory port between the I- and D-cache miss engines:
// optional 8-beat victim writeback, 8-beat refill, one-cycle ack.
// Build option: ROUND_ROBIN_EN selects round-robin instead of fixed D priority.
module l1_mem_arbiter #(
    parameter int WORD_W = 16,
    parameter int BEATS  = 8,
    parameter int ADDR_W = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic                      d_req,
    input  logic                      i_wb,
    input  logic                      d_wb,
    input  logic [ADDR_W-4:0]         i_waddr,
    input  logic [ADDR_W-4:0]         d_waddr,
    input  logic [ADDR_W-4:0]         i_raddr,
    input  logic [ADDR_W-4:0]         d_raddr,
    input  logic [WORD_W*BEATS-1:0]   i_wblock,
    input  logic [WORD_W*BEATS-1:0]   d_wblock,
    output logic                      i_ack,
    output logic                      d_ack,
    output logic [WORD_W*BEATS-1:0]   i_rblock,
    output logic [WORD_W*BEATS-1:0]   d_rblock,
    l1_mem_arbiter_if.master          mem,
    output logic                      busy,
    output logic                      gnt_d
);
    import mem_arb_pkg::arb_req_t;
    import mem_arb_pkg::beat_word;

    localparam logic [1:0] IDLE      = mem_arb_pkg::ST_IDLE;
    localparam logic [1:0] WB        = mem_arb_pkg::ST_WB;
    localparam logic [1:0] RD        = mem_arb_pkg::ST_RD;
    localparam logic [1:0] DONE      = mem_arb_pkg::ST_DONE;
    localparam logic [2:0] LAST_BEAT = 3'd7;

    logic [1:0]                state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    arb_req_t                  req_q, req_d;
    logic                      gnt_d_q, gnt_d_d;
    logic                      i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic [WORD_W*BEATS-1:0]   i_rblock_q, i_rblock_d, d_rblock_q, d_rblock_d;
    logic                      mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]         mem_wdata_q, mem_wdata_d;
    logic                      busy_q, busy_d;
    logic                      win_d_s, any_req_s;

`ifdef ROUND_ROBIN_EN
    logic grant_en_s;
    assign grant_en_s = (state_q == IDLE) && any_req_s;
`endif

    arb_pick u_pick (
`ifdef ROUND_ROBIN_EN
        .clk      (clk),
        .rst      (rst),
        .grant_en (grant_en_s),
`endif
        .i_req    (i_req),
        .d_req    (d_req),
        .win_d    (win_d_s),
        .any_req  (any_req_s)
    );

    // Transfer sequencing: grant in IDLE, count beats on mem_ack, fill rblock.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        gnt_d_d    = gnt_d_q;
        i_rblock_d = i_rblock_q;
        d_rblock_d = d_rblock_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    gnt_d_d = win_d_s;
                    req_d   = win_d_s ? {d_wb, d_waddr, d_raddr, d_wblock}
                                      : {i_wb, i_waddr, i_raddr, i_wblock};
                    cnt_d   = 3'd0;
                    state_d = (win_d_s ? d_wb : i_wb) ? WB : RD;
                end else begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (mem.mem_ack) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 3'd0;
                        state_d = RD;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RD: begin
                if (mem.mem_ack) begin
                    if (gnt_d_q) begin
                        d_rblock_d[int'(cnt_q)*WORD_W +: WORD_W] = mem.mem_rdata;
                    end else begin
                        i_rblock_d[int'(cnt_q)*WORD_W +: WORD_W] = mem.mem_rdata;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 3'd0;
                        state_d = DONE;
                        d_ack_d = gnt_d_q;
                        i_ack_d = ~gnt_d_q;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-port outputs are derived from the next state so they register cleanly.
    always_comb begin
        mem_req_d   = (state_d == WB) || (state_d == RD);
        mem_we_d    = (state_d == WB);
        busy_d      = (state_d != IDLE);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == WB) begin
            mem_addr_d  = {req_d.waddr, cnt_d};
            mem_wdata_d = beat_word(req_d.wblock, cnt_d);
        end else if (state_d == RD) begin
            mem_addr_d  = {req_d.raddr, cnt_d};
        end else begin
            mem_addr_d  = '0;
        end
    end

    // State and output registers; reset abandons any transfer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            req_q       <= '0;
            gnt_d_q     <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rblock_q  <= '0;
            d_rblock_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            gnt_d_q     <= gnt_d_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rblock_q  <= i_rblock_d;
            d_rblock_q  <= d_rblock_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign i_ack         = i_ack_q;
    assign d_ack         = d_ack_q;
    assign i_rblock      = i_rblock_q;
    assign d_rblock      = d_rblock_q;
    assign gnt_d         = gnt_d_q;
    assign busy          = busy_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
